fpu_addsub_sequencer: RTL and testbench

//  Multi-cycle FSM controller for the FP add/sub datapath (exponent compare, sign

---
 rtl/fpu_addsub_sequencer.sv | 138 +++++++++++++
 tb/tb_fpu_addsub_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_sequencer.sv
// rtl/fpu_addsub_sequencer.sv - FP add/sub datapath control FSM; FPU_SEQ_FAST_FLUSH_EN enables single-cycle sticky flush
module fpu_addsub_sequencer #(
    parameter int EXP_W     = 8,
    parameter int ALIGN_MAX = 26,
    parameter int NORM_MAX  = 26
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_add_sub,
    input  logic             i_sign_a,
    input  logic             i_sign_b,
    input  logic [EXP_W-1:0] i_ex_diff,
    input  logic             i_ex_a_gt_b,
    input  logic             i_mant_a_gt_b,
    input  logic             i_special,
    input  logic             i_mant_zero,
    input  logic             i_mant_ovf,
    input  logic             i_mant_msb,
    input  logic             i_exp_min,
    output logic             o_load,
    output logic             o_swap,
    output logic             o_eff_sub,
    output logic             o_align_shift,
    output logic             o_sticky_flush,
    output logic             o_add,
    output logic             o_norm_right,
    output logic             o_norm_left,
    output logic             o_round,
    output logic             o_zero,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy
);

    localparam int AW = $clog2(ALIGN_MAX + 1);
    localparam int NW = $clog2(NORM_MAX + 1);
    localparam logic [EXP_W-1:0] ALIGN_MAX_E = EXP_W'(ALIGN_MAX);
    localparam logic [AW-1:0]    ALIGN_MAX_A = AW'(ALIGN_MAX);
    localparam logic [NW-1:0]    NORM_MAX_N  = NW'(NORM_MAX);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_ROUND = 3'd4;
    localparam logic [2:0] S_POST  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]    state;
    logic [AW-1:0] align_cnt;
    logic [NW-1:0] norm_cnt;
    logic          flush_pend;
    logic          flush_req;
    logic          norm_stop;
    logic [AW-1:0] align_load;

    assign flush_req = (i_ex_diff > ALIGN_MAX_E);
    assign norm_stop = i_mant_msb | i_exp_min | (norm_cnt == NORM_MAX_N);

`ifdef FPU_SEQ_FAST_FLUSH_EN
    // A flushed operand needs no stepwise shifting: one cycle collapses it into sticky.
    assign align_load    = flush_req ? AW'(1) : AW'(i_ex_diff);
    assign o_align_shift = (state == S_ALIGN) && (align_cnt != '0) && !flush_pend;
`else
    assign align_load    = flush_req ? ALIGN_MAX_A : AW'(i_ex_diff);
    assign o_align_shift = (state == S_ALIGN) && (align_cnt != '0);
`endif

    assign o_ready        = (state == S_IDLE) && !i_rst;
    assign o_load         = i_valid && o_ready;
    assign o_busy         = (state != S_IDLE);
    assign o_sticky_flush = (state == S_ALIGN) && flush_pend && (align_cnt == AW'(1));
    assign o_add          = (state == S_ADD);
    assign o_round        = (state == S_ROUND);
    assign o_valid        = (state == S_DONE);
    // Normalise strobes follow the live datapath status within the NORM/POST cycle.
    assign o_norm_right   = ((state == S_NORM) && !i_mant_zero && i_mant_ovf) ||
                            ((state == S_POST) && i_mant_ovf);
    assign o_norm_left    = (state == S_NORM) && !i_mant_zero && !i_mant_ovf && !norm_stop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            align_cnt  <= '0;
            norm_cnt   <= '0;
            flush_pend <= 1'b0;
            o_swap     <= 1'b0;
            o_eff_sub  <= 1'b0;
            o_zero     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (o_load) begin
                        o_eff_sub  <= i_add_sub ^ i_sign_a ^ i_sign_b;
                        o_swap     <= !i_ex_a_gt_b && ((i_ex_diff != '0) || !i_mant_a_gt_b);
                        align_cnt  <= align_load;
                        flush_pend <= flush_req;
                        norm_cnt   <= '0;
                        o_zero     <= 1'b0;
                        if (i_special)
                            state <= S_DONE;
                        else if (i_ex_diff == '0)
                            state <= S_ADD;
                        else
                            state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (align_cnt != '0)
                        align_cnt <= align_cnt - AW'(1);
                    if (align_cnt <= AW'(1))
                        state <= S_ADD;
                end
                S_ADD: state <= S_NORM;
                S_NORM: begin
                    if (i_mant_zero) begin
                        o_zero <= 1'b1;
                        state  <= S_DONE;
                    end else if (i_mant_ovf || norm_stop) begin
                        state <= S_ROUND;
                    end else if (norm_cnt != NORM_MAX_N) begin
                        norm_cnt <= norm_cnt + NW'(1);
                    end
                end
                S_ROUND: state <= S_POST;
                S_POST:  state <= S_DONE;
                S_DONE: begin
                    if (i_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_addsub_sequencer.sv
// tb/tb_fpu_addsub_sequencer.sv - directed and random checks of the add/sub sequencer against a datapath/latency model
module tb_fpu_addsub_sequencer;

    localparam int ALIGN_MAX = 26;
    localparam int NORM_MAX  = 26;
    localparam int LIMIT     = 150;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic       i_add_sub;
    logic       i_sign_a;
    logic       i_sign_b;
    logic [7:0] i_ex_diff;
    logic       i_ex_a_gt_b;
    logic       i_mant_a_gt_b;
    logic       i_special;
    logic       i_mant_zero;
    logic       i_mant_ovf;
    logic       i_mant_msb;
    logic       i_exp_min;
    logic       o_load;
    logic       o_swap;
    logic       o_eff_sub;
    logic       o_align_shift;
    logic       o_sticky_flush;
    logic       o_add;
    logic       o_norm_right;
    logic       o_norm_left;
    logic       o_round;
    logic       o_zero;
    logic       o_valid;
    logic       i_ready;
    logic       o_busy;

    int errors = 0;
    int checks = 0;

    fpu_addsub_sequencer #(.EXP_W(8), .ALIGN_MAX(ALIGN_MAX), .NORM_MAX(NORM_MAX)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_add_sub(i_add_sub), .i_sign_a(i_sign_a), .i_sign_b(i_sign_b),
        .i_ex_diff(i_ex_diff), .i_ex_a_gt_b(i_ex_a_gt_b), .i_mant_a_gt_b(i_mant_a_gt_b),
        .i_special(i_special), .i_mant_zero(i_mant_zero), .i_mant_ovf(i_mant_ovf),
        .i_mant_msb(i_mant_msb), .i_exp_min(i_exp_min), .o_load(o_load),
        .o_swap(o_swap), .o_eff_sub(o_eff_sub), .o_align_shift(o_align_shift),
        .o_sticky_flush(o_sticky_flush), .o_add(o_add), .o_norm_right(o_norm_right),
        .o_norm_left(o_norm_left), .o_round(o_round), .o_zero(o_zero),
        .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    // Cycles spent aligning the smaller operand.
    function automatic int ref_align_cycles(input int ex);
        if (ex == 0) return 0;
        if (ex > ALIGN_MAX) begin
`ifdef FPU_SEQ_FAST_FLUSH_EN
            return 1;
`else
            return ALIGN_MAX;
`endif
        end
        return ex;
    endfunction

    function automatic int ref_shift_steps(input int ex);
        if (ex > ALIGN_MAX) begin
`ifdef FPU_SEQ_FAST_FLUSH_EN
            return 0;
`else
            return ALIGN_MAX;
`endif
        end
        return ex;
    endfunction

    task automatic clear_status();
        i_mant_zero = 1'b0;
        i_mant_ovf  = 1'b0;
        i_mant_msb  = 1'b0;
        i_exp_min   = 1'b0;
    endtask

    // Issues one operation and plays the datapath: status reacts to strobes seen the cycle before.
    task automatic run_op(input string name, input int ex, input bit a_gt_b, input bit mant_gt,
                          input bit add_sub, input bit sa, input bit sb, input bit special,
                          input bit zero_res, input bit ovf_res, input int lz, input int floor_sh,
                          input bit rc, input int rd);
        int  c, a_cyc, l_sh, lat;
        int  n_shift, n_flush, n_add, n_left, n_right, n_round;
        int  lz_rem, shifts;
        bit  added, ovf_now;
        bit  s_add, s_left, s_right, s_round;
        bit  exp_swap, exp_eff, exp_zero;
        a_cyc    = special ? 0 : ref_align_cycles(ex);
        l_sh     = (special || zero_res || ovf_res) ? 0 : min3(lz, floor_sh, NORM_MAX);
        lat      = special ? 1 : (zero_res ? 3 + a_cyc + l_sh : 5 + a_cyc + l_sh);
        exp_swap = (ex != 0) ? !a_gt_b : !mant_gt;
        exp_eff  = add_sub ? (sa == sb) : (sa != sb);
        exp_zero = !special && zero_res;

        i_valid = 1'b1; i_ex_diff = 8'(ex); i_ex_a_gt_b = a_gt_b; i_mant_a_gt_b = mant_gt;
        i_add_sub = add_sub; i_sign_a = sa; i_sign_b = sb; i_special = special;
        clear_status();
        @(negedge i_clk);
        check({name, " accept"}, {30'd0, o_ready, o_load}, 32'd3);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        c = 1; added = 0; ovf_now = 0; lz_rem = lz; shifts = 0;
        n_shift = 0; n_flush = 0; n_add = 0; n_left = 0; n_right = 0; n_round = 0;
        while (c < LIMIT) begin
            i_mant_zero = added && zero_res;
            i_mant_ovf  = ovf_now;
            i_mant_msb  = added && (lz_rem == 0);
            i_exp_min   = added && (shifts >= floor_sh);
            @(negedge i_clk);
            if (o_valid) break;
            n_shift += int'(o_align_shift); n_flush += int'(o_sticky_flush);
            n_add   += int'(o_add);         n_left  += int'(o_norm_left);
            n_right += int'(o_norm_right);  n_round += int'(o_round);
            s_add = o_add; s_left = o_norm_left; s_right = o_norm_right; s_round = o_round;
            @(posedge i_clk); #1;
            if (s_add)   begin added = 1; ovf_now = ovf_res && !zero_res; end
            if (s_left)  begin lz_rem--; shifts++; end
            if (s_right) begin ovf_now = 0; lz_rem = 0; end
            if (s_round) ovf_now = rc;
            c++;
        end
        check({name, " latency"}, c, lat);
        check({name, " align_shift"}, n_shift, special ? 0 : ref_shift_steps(ex));
        check({name, " sticky_flush"}, n_flush, (!special && ex > ALIGN_MAX) ? 1 : 0);
        check({name, " add"}, n_add, special ? 0 : 1);
        check({name, " norm_left"}, n_left, l_sh);
        check({name, " norm_right"}, n_right,
              (special || zero_res) ? 0 : int'(ovf_res) + int'(rc));
        check({name, " round"}, n_round, (special || zero_res) ? 0 : 1);
        check({name, " flags"}, {29'd0, o_zero, o_swap, o_eff_sub},
              {29'd0, exp_zero, exp_swap, exp_eff});
        check({name, " done ready/busy"}, {30'd0, o_ready, o_busy}, 32'd1);
        if (c >= LIMIT) begin
            i_rst = 1'b1; @(posedge i_clk); #1; i_rst = 1'b0;
        end else begin
            for (int k = 0; k < rd; k++) begin
                @(posedge i_clk); #1;
                @(negedge i_clk);
                check({name, " hold"}, {30'd0, o_valid, o_ready}, 32'd2);
            end
            i_ready = 1'b1;
            @(posedge i_clk); #1;
            i_ready = 1'b0;
            clear_status();
            @(negedge i_clk);
            check({name, " release"}, {29'd0, o_valid, o_ready, o_busy}, 32'd2);
        end
        @(posedge i_clk); #1;
    endtask

    initial begin
        int vcount;
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_add_sub = 1'b0;
        i_sign_a = 1'b0; i_sign_b = 1'b0; i_ex_diff = 8'd0; i_ex_a_gt_b = 1'b0;
        i_mant_a_gt_b = 1'b0; i_special = 1'b0;
        clear_status();
        repeat (2) @(posedge i_clk);
        #1;
        i_valid = 1'b1;
        @(negedge i_clk);
        check("reset outputs",
              {19'd0, o_ready, o_busy, o_valid, o_load, o_swap, o_eff_sub, o_align_shift,
               o_sticky_flush, o_add, o_norm_right, o_norm_left, o_round, o_zero}, 32'd0);
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_rst = 1'b0;
        @(negedge i_clk);
        check("post reset idle", {29'd0, o_ready, o_busy, o_valid}, 32'd4);
        @(posedge i_clk); #1;

        run_op("t1 plain add",   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 99, 0, 0);
        run_op("t2 carry out",   3, 1, 0, 0, 1, 1, 0, 0, 1, 0, 99, 0, 0);
        run_op("t3 exact zero",  0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 99, 0, 1);
        run_op("t4 flush",      40, 1, 1, 0, 0, 0, 0, 0, 0, 0, 99, 0, 0);
        run_op("t5 norm left",   1, 1, 1, 1, 0, 0, 0, 0, 0, 5, 99, 0, 4);
        run_op("diff 255",     255, 0, 0, 1, 1, 0, 0, 0, 0, 2, 99, 1, 0);
        run_op("norm saturate",  2, 0, 0, 1, 0, 0, 0, 0, 0, 30, 40, 0, 0);
        run_op("exp floor",     26, 1, 0, 1, 0, 0, 0, 0, 0, 9, 3, 0, 2);
        run_op("diff 27",       27, 0, 1, 0, 1, 0, 0, 0, 1, 0, 99, 1, 0);

        // Reset mid-ALIGN abandons the operation.
        i_valid = 1'b1; i_ex_diff = 8'd10; i_ex_a_gt_b = 1'b1; i_special = 1'b0;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("t6 mid align", {30'd0, o_align_shift, o_busy}, 32'd3);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(negedge i_clk);
        check("t6 ready in reset", {31'd0, o_ready}, 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("t6 idle after reset", {29'd0, o_ready, o_busy, o_valid}, 32'd4);
        vcount = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge i_clk);
            vcount += int'(o_valid);
        end
        check("t6 no valid", vcount, 0);
        @(posedge i_clk); #1;
        run_op("t6 special", 5, 1, 1, 0, 0, 1, 1, 0, 0, 0, 99, 0, 1);

        for (int i = 0; i < 40; i++) begin
            int  ex, r;
            bit  agb;
            r  = int'($urandom_range(0, 9));
            ex = (r == 0) ? 255 : (r < 3) ? int'($urandom_range(27, 60)) : int'($urandom_range(0, 26));
            agb = (ex != 0) ? bit'($urandom_range(0, 1)) : 1'b0;
            run_op($sformatf("rand%0d", i), ex, agb, bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 30)), int'($urandom_range(0, 40)),
                   ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
